// File: rtl/osm_pkg.sv
// Shared types and constants for the online multiplier/accumulator slice sequencer.
// Holds the phase enum, default geometry and the step-counter width helper.
package osm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        INIT,
        RUN,
        FLUSH,
        DONE
    } osm_state_e;

    localparam int N_DEF       = 8;
    localparam int DELTA_DEF   = 3;
    localparam int STALL_CNT_W = 16;

    // Width able to hold every step index plus the precision value itself.
    function automatic int osm_cw(input int n, input int delta);
        return $clog2(n + delta + 1);
    endfunction

endpackage

// File: rtl/osm_digit_sequencer_step_counter.sv
// Step counter for the digit sequencer: counts fired steps and flags the
// phase boundaries (end of online delay, last input digit, last step).
module osm_step_counter
    import osm_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DELTA = DELTA_DEF,
    parameter int CW    = osm_cw(N, DELTA)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] n_eff,
    output logic [CW-1:0] count,
    output logic          at_delta_end,
    output logic          at_input_end,
    output logic          at_last
);

    localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] last_idx;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE_C;
        end
    end

    assign last_idx     = n_eff + DELTA_C - ONE_C;
    assign at_delta_end = (count == DELTA_C - ONE_C);
    assign at_input_end = (count == n_eff - ONE_C);
    assign at_last      = (count == last_idx);

endmodule

// File: rtl/osm_digit_sequencer.sv
// Phase controller for one online (MSD-first) multiplier/accumulator slice.
// Optional build macro OSM_STALL_CNT_EN adds a saturating stall_cycles counter.
module osm_digit_sequencer
    import osm_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DELTA = DELTA_DEF,
    parameter int CW    = osm_cw(N, DELTA)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CW-1:0]          n_digits,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   dp_clr,
    output logic                   dp_en,
    output logic                   zero_feed,
    output logic [CW-1:0]          step_idx,
    output logic                   last_out,
`ifdef OSM_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
    output logic                   done
);

    localparam logic [CW-1:0] N_C     = CW'(N);
    localparam logic [CW-1:0] DELTA_C = CW'(DELTA);

    osm_state_e    state, state_nxt;
    logic [CW-1:0] n_eff;
    logic          cons, prod, step_fire;
    logic          at_delta_end, at_input_end, at_last;
    logic          start_ok, n_digits_ok, cnt_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Out-of-range precisions fall back to full width so an operation still
    // produces at least DELTA+1 digits.
    assign start_ok    = (state == IDLE) && start;
    assign n_digits_ok = (n_digits > DELTA_C) && (n_digits <= N_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_eff <= N_C;
        end else if (start_ok) begin
            n_eff <= n_digits_ok ? n_digits : N_C;
        end
    end

    // NOTE: every signal written here gets a default first; a branch that
    // skips one would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cons      = (state == INIT) || (state == RUN);
        prod      = (state == RUN) || (state == FLUSH);
        in_ready  = cons && (!prod || out_ready);
        out_valid = prod && (!cons || in_valid);
        step_fire = (cons || prod) && (!cons || in_valid) && (!prod || out_ready);
        dp_en     = step_fire;
        dp_clr    = (state == CLR);
        zero_feed = (state == FLUSH);
        busy      = (state != IDLE);
        done      = (state == DONE);
        last_out  = out_valid && at_last;

        unique case (state)
            IDLE:    if (start) state_nxt = CLR;
            CLR:     state_nxt = INIT;
            INIT:    if (step_fire && at_delta_end) state_nxt = RUN;
            RUN:     if (step_fire && at_input_end) state_nxt = FLUSH;
            FLUSH:   if (step_fire && at_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clearing on DONE as well leaves step_idx at 0 while idle.
    assign cnt_clr = (state == CLR) || (state == DONE);

    osm_step_counter #(
        .N     (N),
        .DELTA (DELTA),
        .CW    (CW)
    ) u_step_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (cnt_clr),
        .en           (step_fire),
        .n_eff        (n_eff),
        .count        (step_idx),
        .at_delta_end (at_delta_end),
        .at_input_end (at_input_end),
        .at_last      (at_last)
    );

`ifdef OSM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stall_q <= '0;
        end else if ((cons || prod) && !step_fire && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_osm_digit_sequencer.sv
// Self-checking bench for osm_digit_sequencer: a scoreboard of expected output
// steps is filled at start and drained on every output handshake.
module tb_osm_digit_sequencer;
    import osm_pkg::*;

    localparam int N     = 8;
    localparam int DELTA = 3;
    localparam int CW    = osm_cw(N, DELTA);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] n_digits = '0;
    logic [CW-1:0] step_idx;
    logic          busy, in_ready, out_valid, dp_clr, dp_en, zero_feed, last_out, done;
`ifdef OSM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cycles;
`endif

    osm_digit_sequencer #(
        .N     (N),
        .DELTA (DELTA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_digits     (n_digits),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dp_clr       (dp_clr),
        .dp_en        (dp_en),
        .zero_feed    (zero_feed),
        .step_idx     (step_idx),
        .last_out     (last_out),
`ifdef OSM_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int step;
        bit last;
        bit zero;
    } exp_out_t;

    exp_out_t sb[$];
    exp_out_t mon_e;
    int in_cnt, out_cnt, done_cnt, clr_cnt;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dp_clr) clr_cnt++;
        if (done) done_cnt++;
        if (in_valid && in_ready) begin
            in_cnt++;
            check("in_zero_feed", zero_feed, 0);
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            check("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("out_step", step_idx, mon_e.step);
                check("out_last", last_out, mon_e.last);
                check("out_zero_feed", zero_feed, mon_e.zero);
            end
        end
    end

    // mode: 0 clean, 1 backpressure, 2 starvation, 3 start while busy, 4 mid-op reset
    task automatic run_op(input int nd, input int exp_n, input int mode, input int exp_lat);
        int  t0;
        bit  seen;
        int  exp_stall;
        for (int i = 0; i < exp_n; i++) begin
            sb.push_back('{step: DELTA + i, last: (i == exp_n - 1), zero: (DELTA + i >= exp_n)});
        end
        exp_stall = (mode == 1) ? 2 : (mode == 2) ? 4 : 0;
        in_cnt = 0; out_cnt = 0; done_cnt = 0; clr_cnt = 0;

        @(posedge clk); #1;
        start    = 1'b1;
        n_digits = CW'(nd);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        t0 = cyc;
        @(posedge clk); #1;
        start    = 1'b0;
        n_digits = CW'(4);
        seen     = 1'b0;

        for (int k = 1; k <= 60 && !seen; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            case (mode)
                1: if (k == 6 || k == 7) out_ready = 1'b0;
                2: if (k >= 2 && k <= 5) in_valid = 1'b0;
                3: start = (k == 6 || k == 13);
                4: rst = (k == 8);
                default: ;
            endcase
            @(negedge clk);
            if (k == 1) begin
                check("clr_pulse", dp_clr, 1);
                check("clr_step", step_idx, 0);
            end
            if (mode == 1 && k >= 6 && k <= 8) check("bp_step_hold", step_idx, 4);
            if (mode == 1 && (k == 6 || k == 7)) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_dp_en", dp_en, 0);
            end
            if (mode == 2 && k >= 2 && k <= 5) begin
                check("starve_step", step_idx, 0);
                check("starve_dp_en", dp_en, 0);
                check("starve_out_valid", out_valid, 0);
            end
            if (mode == 4 && k == 9) begin
                check("rst_busy", busy, 0);
                check("rst_step", step_idx, 0);
            end
            if (done) begin
                seen = 1'b1;
                check("latency", cyc - t0, exp_lat);
`ifdef OSM_STALL_CNT_EN
                check("stall_cycles", stall_cycles, exp_stall);
`endif
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;

        @(negedge clk);
        check("idle_after", busy, 0);
        if (exp_lat < 0) begin
            check("no_done_after_rst", done_cnt, 0);
            sb.delete();
        end else begin
            check("done_seen", seen, 1);
            check("done_count", done_cnt, 1);
            check("clr_count", clr_cnt, 1);
            check("in_count", in_cnt, exp_n);
            check("out_count", out_cnt, exp_n);
            check("sb_drained", sb.size(), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_step", step_idx, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_dp_clr", dp_clr, 0);
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 0);
            check("idle_done", done, 0);
        end

        run_op(8, 8, 0, 13);
        run_op(5, 5, 0, 10);
        run_op(2, 8, 0, 13);
        run_op(12, 8, 0, 13);
        run_op(8, 8, 1, 15);
        run_op(8, 8, 2, 17);
        run_op(8, 8, 3, 13);
        run_op(8, 8, 4, -1);
        run_op(6, 6, 0, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/osm_digit_sequencer.md
Name: osm_digit_sequencer

Overview:
- Controller for one online (MSD-first, digit-serial) multiplier/accumulator slice built around the carry-save residual compressor.
- Sequences the slice through three phases for each operation: online-delay initialisation, steady state, and zero-digit flush.
- Drives the datapath clear and enables, and runs valid/ready handshakes on the digit input and digit output streams.
- Sits between the layer scheduler, which issues start, and one compressor/selection datapath.

Parameters:
- N, 8, maximum digits per operand; also the maximum number of output digits.
- DELTA, 3, online delay in digit steps; must satisfy 1 <= DELTA < N.
- CW, $clog2(N+DELTA+1), width of the step counter and of the precision field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- n_digits  in  CW  operand precision for this operation; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  an operand digit pair is present on the input stream.
- in_ready  out  1  the sequencer consumes the input digit pair this cycle.
- out_valid  out  1  the selected output digit is valid.
- out_ready  in  1  the downstream block accepts the output digit.
- dp_clr  out  1  one-cycle clear of the residual (WS/WC) and operand registers.
- dp_en  out  1  residual register update this cycle; equals step_fire.
- zero_feed  out  1  datapath must substitute digit 0 for the input digit (flush phase).
- step_idx  out  CW  index of the current step, 0 .. n_eff+DELTA-1.
- last_out  out  1  qualifies the final output digit.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- States: IDLE, CLR, INIT, RUN, FLUSH, DONE.
- Reset (synchronous, while rst high): state=IDLE; all outputs 0 except out_valid=0, in_ready=0; step_idx=0; n_eff=N.
- Reset wins over every other event and aborts any operation in progress; no done pulse is produced.
- IDLE: when start=1, latch n_eff = n_digits if DELTA < n_digits <= N, otherwise n_eff = N. Go to CLR.
- CLR (one cycle): dp_clr=1, step_idx=0. Go to INIT.
- Per-state flags:
  - cons = state in {INIT, RUN}.
  - prod = state in {RUN, FLUSH}.
- Handshake signals:
  - in_ready = cons & (!prod | out_ready).
  - out_valid = prod & (!cons | in_valid).
  - step_fire = (!cons | in_valid) & (!prod | out_ready) & state in {INIT, RUN, FLUSH}.
- Stalls: when step_fire=0, step_idx and state hold. dp_en=0 and zero_feed holds its value.
- Step counting: each step_fire increments step_idx.
- Transitions on step_fire:
  - INIT -> RUN when step_idx == DELTA-1.
  - RUN -> FLUSH when step_idx == n_eff-1 (last input digit consumed).
  - FLUSH -> DONE when step_idx == n_eff+DELTA-1.
- Per-operation totals: exactly n_eff input digits consumed, exactly n_eff output digits emitted, total n_eff+DELTA steps.
- zero_feed = (state == FLUSH).
- last_out = out_valid & (step_idx == n_eff+DELTA-1).
- DONE (one cycle): done=1, busy=1, then IDLE. A start during DONE is ignored.
- start while busy is ignored, and n_digits is not re-latched.
- Timing: with no stalls, done occurs n_eff+DELTA+2 cycles after the start cycle.
- Combinational paths in_valid->out_valid and out_ready->in_ready are permitted. There is no path from out_valid to in_ready.

Optional Feature:
- Macro OSM_STALL_CNT_EN.
- When defined: extra output stall_cycles, 16 bits. It increments, saturating at 16'hFFFF, on every cycle where state is in {INIT, RUN, FLUSH} and step_fire=0. It clears on rst and on CLR entry, and holds in IDLE and DONE.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package osm_pkg holds:
  - the state enum (IDLE, CLR, INIT, RUN, FLUSH, DONE);
  - default N and DELTA;
  - the CW width function;
  - the STALL_CNT_W=16 constant.
- One sub-module, osm_step_counter: a CW-bit counter with clear, enable, and compare-equal outputs at DELTA-1, n_eff-1 and n_eff+DELTA-1. The FSM and handshake logic stay in the top module.

Test Plan:
- Reset and idle: N=8, DELTA=3, no start -> busy=0, dp_clr=0, out_valid=0, in_ready=0, done=0 for 20 cycles.
- Full precision, no stalls: in_valid=1 and out_ready=1 held high, start with n_digits=8:
  - dp_clr high for 1 cycle;
  - 8 in_ready pulses (steps 0-7) and 8 out_valid pulses (steps 3-10);
  - zero_feed on steps 8-10; last_out at step 10;
  - done exactly 13 cycles after start.
- Reduced and illegal precision:
  - n_digits=5 -> 5 inputs, 5 outputs, done 10 cycles after start;
  - n_digits=2 or n_digits=12 -> treated as 8.
- Backpressure: out_ready toggling 1,0,0,1 during RUN -> step_idx frozen while low, in_ready=0 while low, the same digit count delivered in order, no lost or duplicated step.
- Starvation and mid-operation reset:
  - in_valid=0 for 4 cycles in INIT -> state and step_idx hold;
  - rst asserted at step 6 -> IDLE next cycle, no done pulse, a new start then runs cleanly.
- Ignored start and optional feature:
  - start pulsed during RUN and during DONE -> ignored;
  - with OSM_STALL_CNT_EN defined and 4 injected stall cycles -> stall_cycles=4 at done.
